// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester and memory macro signals of the shared memory port.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding arbiter of IF and MEM requesters onto one memory port.
// Define ARB_PERF_CNT_EN to add the perf_if_stall / perf_d_stall stall counters.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_d_stall,
`endif
  mem_port_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [0:0] state;
  logic       owner, we_q;
  logic [3:0] cnt, starve;
  logic       idle, pick_d, pick_i, done;
  assign idle   = !rst && state == IDLE;
  assign pick_d = idle && bus.d_req && !(bus.if_req && starve == SMAX);
  assign pick_i = idle && bus.if_req && !pick_d;
  assign done   = !rst && state == WAIT && cnt == LAT;
  always_comb begin
    bus.if_gnt    = pick_i;
    bus.d_gnt     = pick_d;
    bus.mem_en    = pick_i || pick_d;
    bus.mem_we    = pick_d && bus.d_we;
    bus.mem_be    = pick_d ? bus.d_be : pick_i ? 4'hF : 4'h0;
    bus.mem_addr  = pick_d ? bus.d_addr : pick_i ? bus.if_addr : 32'd0;
    bus.mem_wdata = pick_d ? bus.d_wdata : 32'd0;
    bus.if_rvalid = done && !owner;
    bus.d_rvalid  = done && owner;
    bus.if_rdata  = (done && !owner) ? bus.mem_rdata : 32'd0;
    bus.d_rdata   = (done && owner && !we_q) ? bus.mem_rdata : 32'd0;
    bus.busy      = !rst && state == WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      we_q   <= 1'b0;
      cnt    <= 4'd0;
      starve <= 4'd0;
    end else if (state == IDLE) begin
      if (pick_d || pick_i) begin
        state  <= WAIT;
        owner  <= pick_d;
        we_q   <= pick_d && bus.d_we;
        cnt    <= 4'd1;
        starve <= (pick_d && bus.if_req) ? (starve == SMAX ? SMAX : starve + 4'd1) : 4'd0;
      end
    end else if (cnt == LAT) begin
      state <= IDLE;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end
`ifdef ARB_PERF_CNT_EN
  logic [31:0] pif_q, pd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pif_q <= 32'd0;
      pd_q  <= 32'd0;
    end else begin
      pif_q <= pif_q + {31'd0, bus.if_req && !bus.if_gnt};
      pd_q  <= pd_q + {31'd0, bus.d_req && !bus.d_gnt};
    end
  end
  assign perf_if_stall = rst ? 32'd0 : pif_q;
  assign perf_d_stall  = rst ? 32'd0 : pd_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plan scenarios plus random traffic against a timestamp-based model.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int free_at = 0;
  int done_at = -1;
  int run = 0;
  logic own = 1'b0;
  logic st = 1'b0;
  logic [31:0] p_if = 0, p_d = 0;
  logic e_if_gnt, e_d_gnt, e_mem_en, e_mem_we, e_if_rvalid, e_d_rvalid, e_busy;
  logic [3:0] e_mem_be;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
  logic s_if_gnt, s_d_gnt, s_mem_en, s_mem_we, s_if_rvalid, s_d_rvalid, s_busy;
  logic [3:0] s_mem_be;
  logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_d_rdata, s_perf_if, s_perf_d;
  mem_port_arbiter_if bus();
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_d_stall;
  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall), .bus(bus));
`else
  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  task automatic step();
    logic idle, gd, gi, rv;
    #1;
    idle = cyc >= free_at;
    gd = !rst && idle && bus.d_req && !(bus.if_req && run >= SMAX);
    gi = !rst && idle && bus.if_req && !gd;
    rv = !rst && cyc == done_at;
    e_if_gnt    = gi;
    e_d_gnt     = gd;
    e_mem_en    = gi || gd;
    e_mem_we    = gd && bus.d_we;
    e_mem_be    = gd ? bus.d_be : gi ? 4'hF : 4'h0;
    e_mem_addr  = gd ? bus.d_addr : gi ? bus.if_addr : 32'd0;
    e_mem_wdata = gd ? bus.d_wdata : 32'd0;
    e_if_rvalid = rv && !own;
    e_d_rvalid  = rv && own;
    e_if_rdata  = e_if_rvalid ? bus.mem_rdata : 32'd0;
    e_d_rdata   = (e_d_rvalid && !st) ? bus.mem_rdata : 32'd0;
    e_busy      = !rst && !idle;
    {s_if_gnt, s_d_gnt, s_mem_en, s_mem_we, s_mem_be} = {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be};
    {s_mem_addr, s_mem_wdata, s_if_rvalid, s_if_rdata} = {bus.mem_addr, bus.mem_wdata, bus.if_rvalid, bus.if_rdata};
    {s_d_rvalid, s_d_rdata, s_busy} = {bus.d_rvalid, bus.d_rdata, bus.busy};
    chk("if_gnt", {31'd0, s_if_gnt}, {31'd0, e_if_gnt});
    chk("d_gnt", {31'd0, s_d_gnt}, {31'd0, e_d_gnt});
    chk("mem_en", {31'd0, s_mem_en}, {31'd0, e_mem_en});
    chk("mem_we", {31'd0, s_mem_we}, {31'd0, e_mem_we});
    chk("mem_be", {28'd0, s_mem_be}, {28'd0, e_mem_be});
    chk("mem_addr", s_mem_addr, e_mem_addr);
    chk("mem_wdata", s_mem_wdata, e_mem_wdata);
    chk("if_rvalid", {31'd0, s_if_rvalid}, {31'd0, e_if_rvalid});
    chk("if_rdata", s_if_rdata, e_if_rdata);
    chk("d_rvalid", {31'd0, s_d_rvalid}, {31'd0, e_d_rvalid});
    chk("d_rdata", s_d_rdata, e_d_rdata);
    chk("busy", {31'd0, s_busy}, {31'd0, e_busy});
`ifdef ARB_PERF_CNT_EN
    s_perf_if = perf_if_stall;
    s_perf_d  = perf_d_stall;
    chk("perf_if", s_perf_if, rst ? 32'd0 : p_if);
    chk("perf_d", s_perf_d, rst ? 32'd0 : p_d);
`endif
    if (rst) begin
      free_at = cyc + 1;
      done_at = -1;
      run = 0;
      p_if = 0;
      p_d = 0;
    end else begin
      p_if = p_if + ((bus.if_req && !gi) ? 32'd1 : 32'd0);
      p_d  = p_d + ((bus.d_req && !gd) ? 32'd1 : 32'd0);
      if (gi || gd) begin
        done_at = cyc + LAT;
        free_at = cyc + LAT + 1;
        own = gd;
        st = gd && bus.d_we;
        run = gi ? 0 : bus.if_req ? ((run + 1 > SMAX) ? SMAX : run + 1) : 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic clear_inputs();
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  initial begin
    clear_inputs();
    @(negedge clk);
    rst = 1;
    step();
    chk("rst_if_gnt_quiet", {31'd0, s_if_gnt}, 32'd0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    bus.if_req = 1; bus.d_req = 1; bus.if_addr = 32'h40;
    step();
    chk("rst_gnt_masked", {30'd0, s_if_gnt, s_d_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, s_mem_en}, 32'd0);
    do_reset();
    // single fetch
    bus.if_req = 1; bus.if_addr = 32'h100;
    step();
    chk("sf_if_gnt", {31'd0, s_if_gnt}, 32'd1);
    chk("sf_mem_en", {31'd0, s_mem_en}, 32'd1);
    chk("sf_mem_addr", s_mem_addr, 32'h100);
    chk("sf_mem_be", {28'd0, s_mem_be}, 32'hF);
    bus.if_req = 0;
    step();
    chk("sf_busy1", {31'd0, s_busy}, 32'd1);
    bus.mem_rdata = 32'h00500093;
    step();
    chk("sf_busy2", {31'd0, s_busy}, 32'd1);
    chk("sf_if_rvalid", {31'd0, s_if_rvalid}, 32'd1);
    chk("sf_if_rdata", s_if_rdata, 32'h00500093);
    bus.mem_rdata = 0;
    step();
    chk("sf_idle", {31'd0, s_busy}, 32'd0);
    do_reset();
    // simultaneous fetch and load
    bus.if_req = 1; bus.if_addr = 32'h104; bus.d_req = 1; bus.d_addr = 32'h2000;
    for (int c = 0; c < 6; c++) begin
      bus.mem_rdata = 32'h1000 + c;
      step();
      chk("sim_d_gnt", {31'd0, s_d_gnt}, {31'd0, c == 0});
      chk("sim_if_gnt", {31'd0, s_if_gnt}, {31'd0, c == 3});
      chk("sim_d_rvalid", {31'd0, s_d_rvalid}, {31'd0, c == 2});
      chk("sim_if_rvalid", {31'd0, s_if_rvalid}, {31'd0, c == 5});
      if (c == 2) chk("sim_d_rdata", s_d_rdata, 32'h1002);
      if (c == 5) chk("sim_if_rdata", s_if_rdata, 32'h1005);
`ifdef ARB_PERF_CNT_EN
      if (c == 4) begin
        chk("sim_perf_if", s_perf_if, 32'd3);
        chk("sim_perf_d", s_perf_d, 32'd0);
      end
`endif
      if (s_d_gnt) bus.d_req = 0;
      if (s_if_gnt) bus.if_req = 0;
    end
    do_reset();
    // starvation bound with both requests held
    bus.if_req = 1; bus.if_addr = 32'h200; bus.d_req = 1; bus.d_addr = 32'h3000;
    for (int c = 0; c < 16; c++) begin
      step();
      chk("stv_d_gnt", {31'd0, s_d_gnt}, {31'd0, c % 3 == 0 && c != 12});
      chk("stv_if_gnt", {31'd0, s_if_gnt}, {31'd0, c == 12});
    end
    do_reset();
    // store ack
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEADBEEF;
    step();
    chk("st_mem_we", {31'd0, s_mem_we}, 32'd1);
    chk("st_mem_be", {28'd0, s_mem_be}, 32'h3);
    chk("st_mem_wdata", s_mem_wdata, 32'hDEADBEEF);
    chk("st_mem_addr", s_mem_addr, 32'h2004);
    bus.d_req = 0;
    step();
    bus.mem_rdata = 32'h12345678;
    step();
    chk("st_d_rvalid", {31'd0, s_d_rvalid}, 32'd1);
    chk("st_d_rdata", s_d_rdata, 32'd0);
    chk("st_no_if_gnt", {31'd0, s_if_gnt}, 32'd0);
    do_reset();
    // reset in the middle of a load
    bus.d_req = 1; bus.d_addr = 32'h2008;
    step();
    chk("rm_d_gnt0", {31'd0, s_d_gnt}, 32'd1);
    bus.d_req = 0; rst = 1;
    step();
    rst = 0; bus.d_req = 1; bus.d_addr = 32'h200C; bus.mem_rdata = 32'hCAFE;
    step();
    chk("rm_no_rvalid", {31'd0, s_d_rvalid}, 32'd0);
    chk("rm_busy", {31'd0, s_busy}, 32'd0);
    chk("rm_d_gnt2", {31'd0, s_d_gnt}, 32'd1);
    bus.d_req = 0;
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(99) == 0);
      bus.mem_rdata = $urandom;
      step();
      if (e_if_gnt || (bus.if_req && $urandom_range(19) == 0)) bus.if_req = 0;
      if (!bus.if_req && $urandom_range(2) == 0) begin
        bus.if_req = 1; bus.if_addr = $urandom;
      end
      if (e_d_gnt || (bus.d_req && $urandom_range(19) == 0)) bus.d_req = 0;
      if (!bus.d_req && $urandom_range(2) == 0) begin
        bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
        bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
